// File: rtl/mlp_stream_accel.sv
// rtl/mlp_stream_accel.sv - streaming two-layer MLP classifier with saturating accumulators
module mlp_stream_accel #(
  parameter int IN_SIZE  = 784,
  parameter int HID_SIZE = 32,
  parameter int OUT_SIZE = 10,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid,
  input  logic [7:0]                  pix_data,
  output logic                        pix_ready,
  output logic [$clog2(IN_SIZE)-1:0]  w1_addr,
  input  logic [HID_SIZE*8-1:0]       w1_rdata,
  input  logic [HID_SIZE*8-1:0]       b1,
  output logic [$clog2(HID_SIZE)-1:0] w2_addr,
  input  logic [OUT_SIZE*8-1:0]       w2_rdata,
  input  logic [OUT_SIZE*8-1:0]       b2,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [3:0]                  res_digit,
  output logic [ACC_W-1:0]            res_score,
  output logic                        res_sat,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);

  localparam int IN_W  = $clog2(IN_SIZE);
  localparam int HID_W = $clog2(HID_SIZE);
  localparam int OUT_W = $clog2(OUT_SIZE);
  localparam int EXT_W = ACC_W + 18;

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L1_DRAIN, S_RELU, S_L2, S_L2_DRAIN, S_ARGMAX, S_RESULT
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [7:0]          pix_q, pix_d;
  logic                mac1_q, mac1_d;
  logic [HID_W-1:0]    hid_cnt_q, hid_cnt_d;
  logic [HID_W-1:0]    hid_idx_q, hid_idx_d;
  logic                mac2_q, mac2_d;
  logic [OUT_W-1:0]    arg_cnt_q, arg_cnt_d;
  logic [OUT_W-1:0]    best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic                sat_q, sat_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic signed [ACC_W-1:0] acc1_q [HID_SIZE];
  logic signed [ACC_W-1:0] acc1_d [HID_SIZE];
  logic [6:0]          act_q [HID_SIZE];
  logic [6:0]          act_d [HID_SIZE];
  logic signed [ACC_W-1:0] acc2_q [OUT_SIZE];
  logic signed [ACC_W-1:0] acc2_d [OUT_SIZE];
  logic [ACC_W:0]      sum1, sum2;

  logic pix_hs, last_pix, last_hid, last_arg;

  // Unsigned 8-bit value times signed 8-bit weight; the product always fits 17 signed bits.
  function automatic logic signed [16:0] mul_uw(input logic [7:0] u, input logic [7:0] w);
    return 17'($signed({1'b0, u})) * 17'($signed(w));
  endfunction

  // Add with clamping to the accumulator range; MSB of the result flags a clamp.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [16:0] p);
    logic signed [EXT_W-1:0] s, hi, lo;
    hi = '0;
    hi[ACC_W-2:0] = '1;
    lo = ~hi;
    s = EXT_W'(a) + EXT_W'(p);
    if (s > hi)      return {1'b1, hi[ACC_W-1:0]};
    else if (s < lo) return {1'b1, lo[ACC_W-1:0]};
    else             return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Scale down then clamp into the 0..127 activation range.
  function automatic logic [6:0] relu(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s[ACC_W-1])              return 7'd0;
    else if (s > ACC_W'(127))    return 7'd127;
    else                         return s[6:0];
  endfunction

  assign pix_ready = (state_q == S_IDLE) || (state_q == S_L1);
  assign pix_hs    = pix_valid & pix_ready;
  assign last_pix  = (pix_cnt_q == IN_W'(IN_SIZE - 1));
  assign last_hid  = (hid_cnt_q == HID_W'(HID_SIZE - 1));
  assign last_arg  = (arg_cnt_q == OUT_W'(OUT_SIZE - 1));

  assign w1_addr   = pix_cnt_q;
  assign w2_addr   = hid_cnt_q;
  assign res_valid = (state_q == S_RESULT);
  assign busy      = (state_q != S_IDLE);
  assign res_digit = 4'(best_idx_q);
  assign res_score = best_q;
  assign res_sat   = sat_q;
  assign frame_cnt = frame_cnt_q;

  // Sequencing: frame phases, address counters and the completed-frame count.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    hid_cnt_d   = hid_cnt_q;
    arg_cnt_d   = arg_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        pix_cnt_d = '0;
        if (pix_hs) begin
          if (last_pix) begin
            state_d = S_L1_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = S_L1;
          end
        end
      end
      S_L1: begin
        if (pix_hs) begin
          if (last_pix) begin
            pix_cnt_d = '0;
            state_d   = S_L1_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_L1_DRAIN: state_d = S_RELU;
      S_RELU: begin
        hid_cnt_d = '0;
        state_d   = S_L2;
      end
      S_L2: begin
        if (last_hid) begin
          hid_cnt_d = '0;
          state_d   = S_L2_DRAIN;
        end else begin
          hid_cnt_d = hid_cnt_q + 1'b1;
        end
      end
      S_L2_DRAIN: begin
        arg_cnt_d = '0;
        state_d   = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (last_arg) begin
          arg_cnt_d = '0;
          state_d   = S_RESULT;
        end else begin
          arg_cnt_d = arg_cnt_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: bias preload, delayed MACs aligned to the weight read latency, ReLU and argmax.
  always_comb begin
    pix_d      = pix_q;
    mac1_d     = pix_hs;
    mac2_d     = (state_q == S_L2);
    hid_idx_d  = hid_cnt_q;
    sat_d      = sat_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    sum1       = '0;
    sum2       = '0;
    for (int j = 0; j < HID_SIZE; j++) begin
      acc1_d[j] = acc1_q[j];
      act_d[j]  = act_q[j];
    end
    for (int o = 0; o < OUT_SIZE; o++) begin
      acc2_d[o] = acc2_q[o];
    end

    if (pix_hs) pix_d = pix_data;

    if (state_q == S_IDLE) begin
      for (int j = 0; j < HID_SIZE; j++) begin
        acc1_d[j] = ACC_W'($signed(b1[j*8 +: 8]));
      end
      if (pix_hs) sat_d = 1'b0;
    end else if (mac1_q) begin
      for (int j = 0; j < HID_SIZE; j++) begin
        sum1      = sat_add(acc1_q[j], mul_uw(pix_q, w1_rdata[j*8 +: 8]));
        acc1_d[j] = sum1[ACC_W-1:0];
        if (sum1[ACC_W]) sat_d = 1'b1;
      end
    end

    if (state_q == S_RELU) begin
      for (int j = 0; j < HID_SIZE; j++) begin
        act_d[j] = relu(acc1_q[j]);
      end
      for (int o = 0; o < OUT_SIZE; o++) begin
        acc2_d[o] = ACC_W'($signed(b2[o*8 +: 8]));
      end
    end

    if (mac2_q) begin
      for (int o = 0; o < OUT_SIZE; o++) begin
        sum2      = sat_add(acc2_q[o], mul_uw({1'b0, act_q[hid_idx_q]}, w2_rdata[o*8 +: 8]));
        acc2_d[o] = sum2[ACC_W-1:0];
        if (sum2[ACC_W]) sat_d = 1'b1;
      end
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    if (state_q == S_ARGMAX) begin
      if ((arg_cnt_q == '0) || (acc2_q[arg_cnt_q] > best_q)) begin
        best_d     = acc2_q[arg_cnt_q];
        best_idx_d = arg_cnt_q;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      pix_q       <= '0;
      mac1_q      <= 1'b0;
      hid_cnt_q   <= '0;
      hid_idx_q   <= '0;
      mac2_q      <= 1'b0;
      arg_cnt_q   <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      sat_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int j = 0; j < HID_SIZE; j++) begin
        acc1_q[j] <= '0;
        act_q[j]  <= '0;
      end
      for (int o = 0; o < OUT_SIZE; o++) begin
        acc2_q[o] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      pix_q       <= pix_d;
      mac1_q      <= mac1_d;
      hid_cnt_q   <= hid_cnt_d;
      hid_idx_q   <= hid_idx_d;
      mac2_q      <= mac2_d;
      arg_cnt_q   <= arg_cnt_d;
      best_idx_q  <= best_idx_d;
      best_q      <= best_d;
      sat_q       <= sat_d;
      frame_cnt_q <= frame_cnt_d;
      for (int j = 0; j < HID_SIZE; j++) begin
        acc1_q[j] <= acc1_d[j];
        act_q[j]  <= act_d[j];
      end
      for (int o = 0; o < OUT_SIZE; o++) begin
        acc2_q[o] <= acc2_d[o];
      end
    end
  end

endmodule
